// File: rtl/nibble_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_pkg
// Brief    : Shared types, constants and width legality helper for the
//            nibble-serial add/subtract sequencer.
// Revision : 1.0
// ============================================================================
package nibble_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIBBLE_W = 4;

   // Returns the nibble count, or 0 when the width is not a legal operand size.
   function automatic int nib_count(input int width);
      if (((width % NIBBLE_W) != 0) || (width < 2 * NIBBLE_W)) begin
         return 0;
      end
      return width / NIBBLE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_seq_if
// Brief    : Request/result bundle between a controller and the sequencer.
// Revision : 1.0
// ============================================================================
interface nibble_add_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, cin, a, b,
      input  ready, done, s, cout, ovf
   );

   modport slave (
      input  start, sub, cin, a, b,
      output ready, done, s, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/nibble_add_seq_full_adder_4b.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_4b
// Brief    : 4-bit ripple-carry adder slice shared across all nibbles.
// Revision : 1.0
// ============================================================================
module full_adder_4b
   import nibble_add_pkg::*;
(
   input  wire logic [NIBBLE_W-1:0] a,
   input  wire logic [NIBBLE_W-1:0] b,
   input  wire logic                ci,
   output logic      [NIBBLE_W-1:0] s,
   output logic                     co
);
   logic [NIBBLE_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

   assign co = c[NIBBLE_W];
endmodule
`default_nettype wire

// File: rtl/nibble_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_seq
// Brief    : WIDTH-bit add/subtract computed one nibble per clock through a
//            single shared 4-bit ripple slice.
// Revision : 1.0
// ============================================================================
module nibble_add_seq
   import nibble_add_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   nibble_add_seq_if.slave  bus
);
   localparam int NIB   = nib_count(WIDTH);
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   if (NIB == 0) begin : g_bad_width
      $error("nibble_add_seq: WIDTH must be a multiple of 4 and >= 8");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
   logic                slice_co;

   assign slice_a = op_a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
   assign slice_b = op_b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

   full_adder_4b u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      s_d     = s_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
               op_a_d  = bus.a;
               op_b_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = slice_s;
            carry_d = slice_co;
            if (idx_q == IDX_W'(NIB - 1)) begin
               // Carry out is registered here so it is already valid during DONE.
               cout_d  = slice_co;
               ovf_d   = slice_a[NIBBLE_W-1] ^ slice_b[NIBBLE_W-1]
                       ^ slice_s[NIBBLE_W-1] ^ slice_co;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         s_q     <= s_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.s     = s_q;
   assign bus.cout  = cout_q;
   assign bus.ovf   = ovf_q;
endmodule
`default_nettype wire
